// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scroll buffer.
// Segment bit order is {g,f,e,d,c,b,a}, and a set bit lights that segment.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SHOW   = 2'd1,
        ST_SCROLL = 2'd2
    } seg_state_e;

    localparam int         CHR_BLANK_BIT = 4;
    localparam int         CHR_HEX_MSB   = 3;
    localparam int         CHR_HEX_LSB   = 0;
    localparam logic [7:0] CHR_BLANK     = 8'h10;
    localparam int         SHOW_MAX      = 4;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational display character to seven-segment pattern encoder.
// A character whose blank bit is set produces no lit segments; the top three bits are ignored.
module seg7_encode
    import seg_pkg::*;
(
    input  logic [7:0] chr_i,
    output logic [6:0] seg_o
);

    logic unused_chr;
    assign unused_chr = ^chr_i[7:5];

    always_comb begin
        seg_o = SEG_BLANK;
        if (!chr_i[CHR_BLANK_BIT]) begin
            seg_o = hex_to_seg(chr_i[CHR_HEX_MSB:CHR_HEX_LSB]);
        end
    end

endmodule

// File: rtl/seg_scroll_buffer.sv
// Character buffer and four-digit window generator, right-justified up to four chars, scrolling beyond.
// Optional SEG_SCROLL_HOLD_EN adds a 'hold' input that freezes the scroll tick counter and position.
//
// state     | meaning
// ST_EMPTY  | no characters stored, display blank
// ST_SHOW   | 1..4 characters, static right-justified
// ST_SCROLL | 5+ characters, window walks chars plus one blank gap
module seg_scroll_buffer
    import seg_pkg::*;
#(
    parameter  int DEPTH    = 16,
    parameter  int TICK_DIV = 25_000_000,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wrValid,
    output logic             wrReady,
    input  logic [7:0]       dataIn,
    output logic [27:0]      dataOut,
    output logic [CNT_W-1:0] count
`ifdef SEG_SCROLL_HOLD_EN
    ,
    input  logic             hold
`endif
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    seg_state_e        state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  pos_q, pos_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [27:0]       data_q, data_d;
    logic              wr_acc;
    logic              hold_act;
    logic              tick_hit;
    logic [CNT_W:0]    win_idx [4];
    logic [7:0]        win_chr [4];
    logic [6:0]        win_seg [4];

`ifdef SEG_SCROLL_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    assign wrReady  = (count_q != FULL_CNT) && !clr;
    assign wr_acc   = wrValid && wrReady;
    assign tick_hit = (state_q == ST_SCROLL) && !hold_act && (tick_q == TICK_LAST);
    assign count    = count_q;
    assign dataOut  = data_q;

    always_comb begin
        mem_d = mem_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q] = dataIn;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pos_d    = pos_q;
        tick_d   = tick_q;
        if (clr) begin
            state_d  = ST_EMPTY;
            wr_ptr_d = '0;
            count_d  = '0;
            pos_d    = '0;
            tick_d   = '0;
        end else begin
            if (wr_acc) begin
                count_d  = count_q + CNT_W'(1);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case (state_q)
                ST_EMPTY: begin
                    if (wr_acc) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (wr_acc && (count_q == CNT_W'(SHOW_MAX))) begin
                        state_d = ST_SCROLL;
                        pos_d   = '0;
                        tick_d  = '0;
                    end
                end
                ST_SCROLL: begin
                    if (!hold_act) begin
                        if (tick_hit) begin
                            tick_d = '0;
                            // Wrap uses the post-write length so an append never strands pos.
                            pos_d  = (pos_q == count_d) ? '0 : pos_q + CNT_W'(1);
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Window is built from the next-state view so writes and ticks show on the same edge.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            win_chr[k] = CHR_BLANK;
            win_idx[k] = {1'b0, pos_d} + (CNT_W + 1)'(SHOW_MAX - 1 - k);
            if (win_idx[k] > {1'b0, count_d}) begin
                win_idx[k] = win_idx[k] - ({1'b0, count_d} + (CNT_W + 1)'(1));
            end
            case (state_d)
                ST_SHOW: begin
                    if (CNT_W'(k) < count_d) begin
                        win_chr[k] = mem_d[PTR_W'(count_d - CNT_W'(k) - CNT_W'(1))];
                    end
                end
                ST_SCROLL: begin
                    if (win_idx[k] != {1'b0, count_d}) begin
                        win_chr[k] = mem_d[PTR_W'(win_idx[k])];
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_enc
        seg7_encode u_enc (
            .chr_i (win_chr[g]),
            .seg_o (win_seg[g])
        );
    end

    assign data_d = {win_seg[3], win_seg[2], win_seg[1], win_seg[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pos_q    <= '0;
            tick_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pos_q    <= pos_d;
            tick_q   <= tick_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_seg_scroll_buffer.sv
// Randomized bench for seg_scroll_buffer against a queue-based window model.
module tb_seg_scroll_buffer;

    localparam int DEPTH    = 16;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 5;
`ifdef SEG_SCROLL_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             clr     = 1'b0;
    logic             wrValid = 1'b0;
    logic             hold_r  = 1'b0;
    logic [7:0]       dataIn  = 8'h00;
    logic             wrReady;
    logic [27:0]      dataOut;
    logic [CNT_W-1:0] count;

    int errors = 0;
    int checks = 0;

    logic [7:0] chars [$];
    int         m_pos  = 0;
    int         m_tick = 0;

    logic [6:0] SEGTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scroll_buffer #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wrValid (wrValid),
        .wrReady (wrReady),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .count   (count)
`ifdef SEG_SCROLL_HOLD_EN
        ,
        .hold    (hold_r)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc(input logic [7:0] c);
        return c[4] ? 7'h00 : SEGTAB[c[3:0]];
    endfunction

    function automatic logic [27:0] exp_word();
        int         n;
        int         i;
        logic [7:0] c;
        logic [27:0] w;
        n = chars.size();
        w = '0;
        for (int k = 0; k < 4; k++) begin
            c = 8'h10;
            if (n >= 1 && n <= 4) begin
                if (k < n) c = chars[n - 1 - k];
            end else if (n >= 5) begin
                i = (m_pos + 3 - k) % (n + 1);
                if (i < n) c = chars[i];
            end
            w[k*7 +: 7] = enc(c);
        end
        return w;
    endfunction

    task automatic model_step(input logic c, input logic v, input logic [7:0] d, input logic h);
        int n;
        bit scr;
        n   = chars.size();
        scr = (n >= 5);
        if (c) begin
            chars.delete();
            m_pos  = 0;
            m_tick = 0;
        end else begin
            if (v && n < DEPTH) chars.push_back(d);
            if (scr) begin
                if (!h) begin
                    if (m_tick == TICK_DIV - 1) begin
                        m_tick = 0;
                        m_pos  = (m_pos + 1) % (chars.size() + 1);
                    end else begin
                        m_tick++;
                    end
                end
            end else begin
                m_pos  = 0;
                m_tick = 0;
            end
        end
    endtask

    task automatic cycle(input logic c, input logic v, input logic [7:0] d, input logic h);
        clr     = c;
        wrValid = v;
        dataIn  = d;
        hold_r  = h;
        #1;
        chk("wrReady", {31'd0, wrReady}, {31'd0, (!c && chars.size() < DEPTH)});
        @(posedge clk);
        model_step(c, v, d, h && HOLD_EN);
        #1;
        chk("count", {27'd0, count}, chars.size());
        chk("dataOut", {4'd0, dataOut}, {4'd0, exp_word()});
    endtask

    initial begin
        logic [27:0] held;

        #12;
        chk("rst_dataOut", {4'd0, dataOut}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_wrReady", {31'd0, wrReady}, 32'd1);
        rst = 1'b0;

        cycle(1'b0, 1'b1, 8'h01, 1'b0);
        cycle(1'b0, 1'b1, 8'h02, 1'b0);
        chk("two_d0", {25'd0, dataOut[6:0]}, 32'h5B);
        chk("two_d1", {25'd0, dataOut[13:7]}, 32'h06);
        chk("two_hi", {18'd0, dataOut[27:14]}, 32'd0);
        chk("two_cnt", {27'd0, count}, 32'd2);

        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 8'($urandom_range(0, 31)), 1'b0);
        chk("full_ready", {31'd0, wrReady}, 32'd0);
        chk("full_cnt", {27'd0, count}, 32'd16);

        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
        chk("scr_start", {4'd0, dataOut}, {4'd0, 7'h3F, 7'h06, 7'h5B, 7'h4F});
        for (int i = 0; i < 27; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("scr_wrap", {4'd0, dataOut}, {4'd0, 7'h3F, 7'h06, 7'h5B, 7'h4F});
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);

        cycle(1'b1, 1'b1, 8'h07, 1'b0);
        chk("clrwr_cnt", {27'd0, count}, 32'd0);
        chk("clrwr_data", {4'd0, dataOut}, 32'd0);

`ifdef SEG_SCROLL_HOLD_EN
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'(i + 8), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        held = dataOut;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            chk("hold_const", {4'd0, dataOut}, {4'd0, held});
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
`else
        held = '0;
`endif

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 2) != 0,
                  8'($urandom),
                  $urandom_range(0, 3) == 0);
        end

        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom_range(0, 15)), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dataOut", {4'd0, dataOut}, 32'd0);
        chk("arst_count", {27'd0, count}, 32'd0);
        chk("arst_wrReady", {31'd0, wrReady}, 32'd1);
        chars.delete();
        m_pos  = 0;
        m_tick = 0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scroll_buffer.md
# seg_scroll_buffer

Character buffer and scrolling window generator for the four-digit seven-segment display path. It accepts display characters over a valid/ready write port and stores up to DEPTH of them in order. It emits a registered 28-bit segment word (four digits × seven segments) that drives the four-digit multiplexing driver's `in` bus directly. Messages of four characters or fewer are shown right-justified and static; longer messages scroll left, one position per tick, and wrap.

## Interface
- `DEPTH`, 16: buffer capacity in characters; power of two, ≥ 8.
- `TICK_DIV`, 25_000_000: clock cycles per scroll step; ≥ 2.
- `clk` input 1: system clock; all state is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clr` input 1: synchronous clear; empties the buffer.
- `wrValid` input 1: write request.
- `wrReady` output 1: `!full && !clr`; the write is accepted on a cycle where `wrValid && wrReady`.
- `dataIn` input 8: character. `[4]=1` selects blank; otherwise `[3:0]` is a hex digit. `[7:5]` are ignored.
- `dataOut` output 28: registered segment word. Digit 3 (leftmost) is `[27:21]` and digit 0 (rightmost) is `[6:0]`. Bit order per digit is g,f,e,d,c,b,a (MSB to LSB). Segments are active-high.
- `count` output log2(DEPTH)+1: number of stored characters.

## Operation
- Storage: a circular buffer with write pointer and count. Entry 0 is the oldest character. Characters are never popped individually; only `clr` or `rst` removes them.
- States:
  - EMPTY: count=0.
  - SHOW: 1 ≤ count ≤ 4.
  - SCROLL: count ≥ 5.
- State transitions:
  - Accepted write: EMPTY→SHOW, or SHOW→SCROLL when count goes 4→5.
  - `clr`: any state → EMPTY.
- EMPTY: `dataOut` is 0 (all blank).
- SHOW: digit 0 is the newest character, with older characters to its left. Unused leftmost digits are blank.
- SCROLL window:
  - The scroll sequence is S = chars[0..count-1] followed by one blank gap, so its length is L = count+1.
  - Digit k (k=3..0) shows S[(pos+3-k) mod L].
  - `pos` advances by 1 on each tick and wraps from L-1 to 0.
- Entering SCROLL sets pos=0 and the tick counter to 0.
- Write while in SCROLL: the character is appended and L grows. `pos` is unchanged, but the window immediately reflects the new L.
- Full (count=DEPTH): `wrReady`=0 and `wrValid` is ignored. No overwrite occurs.
- `clr` together with `wrValid`: clear wins and the write is not accepted, since `wrReady` is 0.
- Encoding:
  - Hex 0–F uses the standard patterns. Examples: 0=0x3F, 1=0x06, 2=0x5B, 8=0x7F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
  - Blank = 0x00.

## Timing
- Reset values:
  - `dataOut`=0, `wrReady`=1, `count`=0.
  - pos=0, tick counter=0, state EMPTY.
- Write latency: a write accepted at edge N appears in `count` and `dataOut` after edge N+1. `dataOut` is registered from the next-state view.
- Tick generation:
  - The counter runs 0..TICK_DIV-1 only in SCROLL.
  - It pulses when it reaches TICK_DIV-1, then wraps to 0.
  - The first pos advance occurs TICK_DIV cycles after entering SCROLL.
  - `dataOut` updates one cycle after the tick.
- `clr` at edge N: EMPTY and `dataOut`=0 after edge N+1.
- Reset mid-scroll returns everything to the reset values asynchronously.

## Configuration
- `SEG_SCROLL_HOLD_EN` defined:
  - Adds input port `hold` (1 bit).
  - While `hold`=1, the tick counter and pos freeze at their current values.
  - Writes and `clr` still work; `clr` still resets pos.
- `SEG_SCROLL_HOLD_EN` undefined: the `hold` port does not exist and scrolling is never paused.

## Structure
- Package `seg_pkg`:
  - Segment pattern constants for 0–F and blank.
  - Character-field positions (blank bit 4, hex bits 3:0).
  - State encoding (EMPTY/SHOW/SCROLL).
- Sub-module `seg7_encode`: combinational, 8-bit character in, 7-bit pattern out. It is instantiated four times, once per window digit.
- The top level holds the buffer, pointers, tick counter, FSM and output register.

## Test plan
- Reset asserted mid-operation → `dataOut`=0, `wrReady`=1, `count`=0 asynchronously.
- Write 0x01, then 0x02 → after the second write's next edge: `dataOut[13:7]`=0x06, `[6:0]`=0x5B, `[27:14]`=0, `count`=2.
- Write 16 characters with `wrValid` held high → `wrReady`=0 after the 16th is accepted, `count`=16, 17th value not stored.
- TICK_DIV=4, write 0x00–0x05 (L=7) → window sequence 0,1,2,3 → 1,2,3,4 → 2,3,4,5 → 3,4,5,blank → 4,5,blank,0 → …, advancing every 4 cycles, returning to 0,1,2,3 after 7 ticks.
- `clr`=1 together with `wrValid`=1 in SCROLL → next edge: `count`=0, `dataOut`=0, write not accepted.
- `SEG_SCROLL_HOLD_EN` defined, `hold`=1 for 20 cycles with TICK_DIV=4 → `dataOut` constant. After release, the next advance occurs after the remaining tick count.
